// File: rtl/pixel_writer_if.sv
// Pixel-in / framebuffer-out bundle for pixel_writer: generator strobe side,
// memory write port and status flags.
interface pixel_writer_if #(
  parameter int COLOR_W = 16,
  parameter int ADDR_W  = 19
);
  logic               plot;
  logic [10:0]        x;
  logic [9:0]         y;
  logic [COLOR_W-1:0] color;
  logic               line_done;
  logic               clr_overflow;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               mem_write;
  logic               mem_waitrequest;
  logic               fifo_full;
  logic               overflow;
  logic               busy;
  logic               flush_done;

  modport slave (
    input  plot, x, y, color, line_done, clr_overflow, mem_waitrequest,
    output mem_addr, mem_wdata, mem_write, fifo_full, overflow, busy, flush_done
  );

  modport master (
    output plot, x, y, color, line_done, clr_overflow, mem_waitrequest,
    input  mem_addr, mem_wdata, mem_write, fifo_full, overflow, busy, flush_done
  );
endinterface

// File: rtl/pixel_writer.sv
// Clips incoming pixels, buffers them in a FIFO and writes them to a linear
// framebuffer through a waitrequest memory port; reports end-of-line when drained.
module pixel_writer #(
  parameter int H_RES   = 800,
  parameter int V_RES   = 480,
  parameter int COLOR_W = 16,
  parameter int ADDR_W  = 19,
  parameter int DEPTH   = 16
) (
  input  logic           clk,
  input  logic           reset,
  pixel_writer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [10:0] X_LIM = 11'(H_RES);
  localparam logic [9:0]  Y_LIM = 10'(V_RES);

  typedef struct packed {
    logic [10:0]        x;
    logic [9:0]         y;
    logic [COLOR_W-1:0] color;
  } pix_t;

  pix_t              r_mem [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [PW:0]       r_count;
  logic              r_vld;
  logic [ADDR_W-1:0] r_addr;
  logic [COLOR_W-1:0] r_data;
  logic              r_ovf;
  logic              r_pend;
  logic              r_flush;

  logic              w_in_range, w_full, w_empty;
  logic              w_accept, w_pop, w_push, w_loss;
  logic [PW:0]       w_count_nxt;
  logic              w_vld_nxt, w_pend_eff, w_idle_nxt;
  pix_t              w_head, w_pix;
  logic [ADDR_W-1:0] w_addr;

  assign w_in_range = bus.plot && (bus.x < X_LIM) && (bus.y < Y_LIM);
  assign w_full     = (r_count == (PW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_accept   = r_vld && !bus.mem_waitrequest;
  assign w_pop      = !w_empty && (!r_vld || w_accept);
  // a full FIFO still takes a pixel when its head leaves on the same edge
  assign w_push     = w_in_range && (!w_full || w_pop);
  assign w_loss     = w_in_range && w_full && !w_pop;

  assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign w_vld_nxt   = w_pop || (r_vld && !w_accept);
  assign w_idle_nxt  = (w_count_nxt == '0) && !w_vld_nxt;
  // a pixel arriving with line_done keeps the unit busy, so it joins that line
  assign w_pend_eff  = r_pend || bus.line_done;

  assign w_pix  = '{x: bus.x, y: bus.y, color: bus.color};
  assign w_head = r_mem[r_rptr];
  assign w_addr = ADDR_W'(w_head.y) * ADDR_W'(H_RES) + ADDR_W'(w_head.x);

  // storage needs no reset: only pointers and count define occupancy
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_pix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_pend  <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_vld   <= w_vld_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_addr <= w_addr;
        r_data <= w_head.color;
      end
      if (w_loss)                 r_ovf <= 1'b1;
      else if (bus.clr_overflow)  r_ovf <= 1'b0;
      r_flush <= w_pend_eff && w_idle_nxt;
      r_pend  <= w_pend_eff && !w_idle_nxt;
    end
  end

  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_data;
  assign bus.mem_write  = r_vld;
  assign bus.fifo_full  = w_full;
  assign bus.overflow   = r_ovf;
  assign bus.busy       = !w_empty || r_vld;
  assign bus.flush_done = r_flush;
endmodule

// File: tb/tb_pixel_writer.sv
// Directed + random bench for pixel_writer; expectations come from a queue model
// of pixels held by the unit (capacity DEPTH+1, head presented one edge after entry).
module tb_pixel_writer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_writer_if #(.COLOR_W(16), .ADDR_W(19)) bus ();

  pixel_writer #(.H_RES(800), .V_RES(480), .COLOR_W(16), .ADDR_W(19), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { int addr; int data; int born; } ent_t;
  ent_t mq[$];
  int   cyc = 0;
  bit   m_ov = 0, m_pend = 0, m_flush = 0;
  int   n_assert = 0, n_fail = 0, n_writes = 0, n_flush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // checks the state left by the previous edge, then applies inputs for one edge
  task automatic step(input bit p, input int xx, input int yy, input int c,
                      input bit ld, input bit clr, input bit wr);
    bit exp_wr, acc, inr, lost, pend_eff;
    exp_wr = (mq.size() > 0) && (mq[0].born < cyc - 1);
    chk("mem_write", bus.mem_write, exp_wr);
    if (exp_wr) begin
      chk("mem_addr", bus.mem_addr, mq[0].addr);
      chk("mem_wdata", bus.mem_wdata, mq[0].data);
    end
    chk("busy", bus.busy, mq.size() > 0);
    chk("fifo_full", bus.fifo_full, mq.size() == DEPTH + 1);
    chk("overflow", bus.overflow, m_ov);
    chk("flush_done", bus.flush_done, m_flush);
    if (bus.flush_done) n_flush++;
    bus.plot = p; bus.x = 11'(xx); bus.y = 10'(yy); bus.color = 16'(c);
    bus.line_done = ld; bus.clr_overflow = clr; bus.mem_waitrequest = wr;
    acc = exp_wr && !wr;
    if (acc) begin
      void'(mq.pop_front());
      n_writes++;
    end
    inr  = p && (xx < 800) && (yy < 480);
    lost = inr && (mq.size() >= DEPTH + 1);
    if (inr && !lost) mq.push_back('{yy * 800 + xx, c, cyc});
    if (lost) m_ov = 1;
    else if (clr) m_ov = 0;
    pend_eff = m_pend || ld;
    m_flush  = pend_eff && (mq.size() == 0);
    m_pend   = pend_eff && !m_flush;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.plot = 0; bus.line_done = 0; bus.clr_overflow = 0; bus.mem_waitrequest = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_ov = 0; m_pend = 0; m_flush = 0;
  endtask

  task automatic idle(input int n, input bit wr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, wr);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && mq.size() > 0; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("drain_done", bus.busy, 1'b0);
  endtask

  initial begin
    int w0;
    bus.plot = 0; bus.x = 0; bus.y = 0; bus.color = 0;
    bus.line_done = 0; bus.clr_overflow = 0; bus.mem_waitrequest = 0;
    @(negedge clk);
    do_reset();
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 19'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    idle(2, 0);

    // single pixel (3,2): write two cycles after plot, then flush on next cycle
    step(1, 3, 2, 'hF800, 0, 0, 0);
    chk("single_lat0", bus.mem_write, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("single_wr", bus.mem_write, 1'b1);
    chk("single_addr", bus.mem_addr, 19'd1603);
    chk("single_data", bus.mem_wdata, 16'hF800);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("single_once", bus.mem_write, 1'b0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("single_flush", bus.flush_done, 1'b1);
    idle(2, 0);

    // clipping
    w0 = n_writes;
    step(1, 800, 0, 'h1111, 0, 0, 0);
    step(1, 0, 480, 'h2222, 0, 0, 0);
    step(1, 2047, 1023, 'h3333, 0, 0, 0);
    idle(3, 0);
    chk("clip_nowrite", n_writes - w0, 0);
    chk("clip_no_ovf", bus.overflow, 1'b0);
    step(1, 799, 479, 'h4444, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("corner_addr", bus.mem_addr, 19'd383999);
    drain();

    // backpressure: 20 pixels into a stalled port, 3 are lost
    for (int i = 0; i < 20; i++) step(1, 10 + i, 7, 'hA000 + i, 0, 0, 1);
    chk("bp_full", bus.fifo_full, 1'b1);
    chk("bp_ovf", bus.overflow, 1'b1);
    w0 = n_writes;
    drain();
    chk("bp_writes", n_writes - w0, 17);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("bp_clr", bus.overflow, 1'b0);

    // full FIFO: push on the same edge as a pop is accepted
    for (int i = 0; i < DEPTH + 1; i++) step(1, i, 20, 'hB000 + i, 0, 0, 1);
    chk("pp_full", bus.fifo_full, 1'b1);
    chk("pp_noovf0", bus.overflow, 1'b0);
    step(1, 500, 20, 'hBEEF, 0, 0, 0);
    chk("pp_noovf", bus.overflow, 1'b0);
    chk("pp_still_full", bus.fifo_full, 1'b1);
    drain();

    // flush ordering with waitrequest toggling 1,0,1,0
    n_flush = 0;
    for (int i = 0; i < 5; i++) step(1, 100 + i, 300, 'hC000 + i, 0, 0, (i % 2) == 0);
    step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, (i % 2) == 1);
    chk("flush_once", n_flush, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 900), $urandom_range(0, 540),
           $urandom_range(0, 65535), $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    drain();
    step(0, 0, 0, 0, 0, 1, 0);
    idle(2, 0);

    // reset with 6 pixels buffered: nothing more is written, no flush
    for (int i = 0; i < 6; i++) step(1, 40 + i, 41, 'hD000 + i, i == 5, 0, 1);
    do_reset();
    chk("mrst_write", bus.mem_write, 1'b0);
    chk("mrst_busy", bus.busy, 1'b0);
    w0 = n_writes;
    n_flush = 0;
    idle(6, 0);
    chk("mrst_nowrite", n_writes - w0, 0);
    chk("mrst_noflush", n_flush, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
